// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: next-PC input, instruction memory port and decode handshake.
// The master modport is the fetch unit's view; slave is the surrounding datapath/memory.
interface instr_fetch_unit_if;
    // Next-PC resolution from the branch logic
    logic [63:0] NextPC;
    logic        NextPCValid;

    // Instruction memory request/grant/response
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemGnt;
    logic [31:0] IMemRdata;
    logic        IMemRvalid;

    // Decode handshake
    logic [31:0] Instruction;
    logic        InstrValid;
    logic        InstrReady;

    // Status
    logic [63:0] CurrentPC;
    logic        Fault;
    logic [31:0] FetchCount;

    modport master (
        input  NextPC,
        input  NextPCValid,
        output IMemReq,
        output IMemAddr,
        input  IMemGnt,
        input  IMemRdata,
        input  IMemRvalid,
        output Instruction,
        output InstrValid,
        input  InstrReady,
        output CurrentPC,
        output Fault,
        output FetchCount
    );

    modport slave (
        output NextPC,
        output NextPCValid,
        input  IMemReq,
        input  IMemAddr,
        output IMemGnt,
        output IMemRdata,
        output IMemRvalid,
        input  Instruction,
        input  InstrValid,
        output InstrReady,
        input  CurrentPC,
        input  Fault,
        input  FetchCount
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Sequential LEGv8 fetch front end: one outstanding fetch, hands the instruction to decode,
// then waits for the resolved next PC. Misaligned targets park the unit in a sticky fault.
module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input logic                   CLK,
    input logic                   resetl,
    instr_fetch_unit_if.master    bus
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StValid,
        StExec,
        StFault
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    // Next-state logic; inputs not relevant to the current state are ignored by construction.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                // A same-cycle response is not accepted; only the grant counts here.
                if (bus.IMemGnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (bus.IMemRvalid) begin
                    instr_d = bus.IMemRdata;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (bus.InstrReady) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                    state_d       = StExec;
                end
            end
            StExec: begin
                if (bus.NextPCValid) begin
                    if (bus.NextPC[1:0] == 2'b00) begin
                        pc_d    = bus.NextPC;
                        state_d = StReq;
                    end else begin
                        fault_d = 1'b1;
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            state_q       <= StIdle;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free per cycle.
    always_comb begin
        bus.IMemReq     = (state_q == StReq);
        bus.InstrValid  = (state_q == StValid);
        bus.IMemAddr    = pc_q;
        bus.CurrentPC   = pc_q;
        bus.Instruction = instr_q;
        bus.Fault       = fault_q;
        bus.FetchCount  = fetch_count_q;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

- Sequential fetch front end of the LEGv8 datapath, and the consumer of the next-PC value produced by the branch/next-PC logic.
- Holds the architectural PC register and fetches one 32-bit instruction per PC from instruction memory over a request/grant/response interface.
- Presents each instruction to decode with a valid/ready handshake, then waits for the resolved next PC before fetching again.
- Only one fetch is ever outstanding; it also flags misaligned targets and counts delivered instructions.

## Interface
Parameters:
- RESET_PC, 64'h0, PC value loaded on reset; must be word-aligned.

Ports (clock and reset first):
- CLK  input  1  single clock for the whole block; all state changes on its rising edge.
- resetl  input  1  asynchronous, active-low reset.
- NextPC  input  64  resolved next PC from the next-PC logic.
- NextPCValid  input  1  NextPC is valid this cycle (current instruction resolved).
- IMemReq  output  1  fetch request to instruction memory.
- IMemAddr  output  64  fetch address; equals CurrentPC.
- IMemGnt  input  1  memory accepted the request this cycle.
- IMemRdata  input  32  instruction word returned.
- IMemRvalid  input  1  IMemRdata is valid this cycle.
- Instruction  output  32  registered instruction to decode.
- InstrValid  output  1  Instruction is valid.
- InstrReady  input  1  decode accepts Instruction this cycle.
- CurrentPC  output  64  PC of the instruction being fetched or held.
- Fault  output  1  sticky misaligned-target flag.
- FetchCount  output  32  instructions delivered to decode; wraps at 2^32.

## Operation
- States:
  - IDLE: reset state.
  - REQ: IMemReq=1.
  - WAIT: awaiting response.
  - VALID: InstrValid=1.
  - EXEC: awaiting NextPCValid.
  - FAULT: terminal error state.
- Transitions:
  - IDLE -> REQ unconditionally, one cycle after reset release.
  - REQ -> WAIT when IMemGnt=1; stay in REQ otherwise.
  - WAIT -> VALID when IMemRvalid=1; Instruction <= IMemRdata on that edge.
  - VALID -> EXEC when InstrReady=1; FetchCount increments by 1, modulo 2^32.
  - EXEC, NextPCValid=1, NextPC[1:0]==0: CurrentPC <= NextPC, go to REQ.
  - EXEC, NextPCValid=1, NextPC[1:0]!=0: CurrentPC unchanged, Fault <= 1, go to FAULT.
  - FAULT: remains there until reset; IMemReq=0 and InstrValid=0 throughout.
- IMemAddr is driven from the CurrentPC register; it is stable whenever IMemReq=1.
- IMemReq is asserted only in REQ; InstrValid only in VALID; both decode directly from state.
- Instruction holds its value until the next capture.
- Ignored inputs:
  - IMemRvalid outside WAIT.
  - IMemGnt outside REQ.
  - NextPCValid outside EXEC.
- IMemGnt and IMemRvalid together in REQ: only the grant is taken (go to WAIT); the response must come in a later cycle.
- The PC is only ever replaced wholesale by NextPC, so there is no PC arithmetic and no PC wrap concern.

## Timing
- Reset values (resetl low):
  - state = IDLE
  - CurrentPC = IMemAddr = RESET_PC
  - IMemReq = 0, InstrValid = 0
  - Instruction = 32'h0, Fault = 0, FetchCount = 0
- Reset asserted mid-operation, in any state: all registers return to the values above immediately, without waiting for CLK. Any in-flight memory response is dropped.
- Minimum fetch loop with zero memory wait and immediate ready/resolve, 4 cycles per instruction:
  - cycle n: REQ, granted.
  - n+1: WAIT, Rvalid.
  - n+2: VALID, Ready.
  - n+3: EXEC, NextPCValid.
  - n+4: REQ at the new PC.
- First IMemReq is asserted in the second cycle after resetl rises.
- Each stall input extends exactly its own state: IMemGnt low holds REQ, IMemRvalid low holds WAIT, InstrReady low holds VALID, NextPCValid low holds EXEC.

## Test plan
- Reset with RESET_PC=64'h100, then grant, Rvalid with 32'h8B020020, Ready, NextPC=64'h104 -> IMemAddr=0x100 with IMemReq at cycle 2; Instruction=32'h8B020020 with InstrValid; FetchCount=1; next IMemReq at 0x104.
- Hold IMemGnt low 3 cycles, then hold InstrReady low 2 cycles -> IMemReq and IMemAddr stable for 4 cycles; InstrValid and Instruction stable for 3 cycles; no duplicate count.
- Branch: NextPC=64'h80 in EXEC -> CurrentPC=0x80 on the next edge and the next request goes to 0x80; stray NextPCValid pulses during REQ, WAIT and VALID change nothing.
- NextPC=64'h102 in EXEC -> Fault=1, no further IMemReq for 10 cycles; after a resetl pulse, Fault=0 and fetch restarts at RESET_PC.
- resetl dropped asynchronously while in WAIT, mid-cycle -> all outputs reach reset values before the next CLK edge; a late IMemRvalid is ignored.
- Preload FetchCount to 32'hFFFFFFFF (force) and deliver one instruction -> FetchCount=0.
